axi_traffic_gen: RTL and testbench

Single-master AXI4 burst traffic generator that sits directly upstream of the zero-data memory sink/source and drives its slave port. It issues a programmed number of INCR read or write bursts, one burst in flight at a time. Read data is checked against an expected all-zero value and non-OKAY responses are counted. It reports elapsed cycles for bandwidth measurement. It is used in SoC bring-up and benches to exercise interconnect paths ending in a zero memory.

---
 rtl/axi_traffic_gen_pkg.sv | 79 +++++++
 rtl/axi_traffic_gen.sv | 159 +++++++++++++++
 tb/tb_axi_traffic_gen.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/axi_traffic_gen_pkg.sv
// axi_traffic_gen_pkg: default AXI4+ATOP channel and request/response structs
// for axi_traffic_gen. Widths: 32-bit address, 64-bit data, 1-bit ID, 1-bit user.
package axi_traffic_gen_pkg;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 64;
  localparam int unsigned IW = 1;
  localparam int unsigned UW = 1;

  typedef struct packed {
    logic [IW-1:0]   id;
    logic [AW-1:0]   addr;
    logic [7:0]      len;
    logic [2:0]      size;
    logic [1:0]      burst;
    logic            lock;
    logic [3:0]      cache;
    logic [2:0]      prot;
    logic [3:0]      qos;
    logic [3:0]      region;
    logic [5:0]      atop;
    logic [UW-1:0]   user;
  } aw_chan_t;

  typedef struct packed {
    logic [IW-1:0]   id;
    logic [AW-1:0]   addr;
    logic [7:0]      len;
    logic [2:0]      size;
    logic [1:0]      burst;
    logic            lock;
    logic [3:0]      cache;
    logic [2:0]      prot;
    logic [3:0]      qos;
    logic [3:0]      region;
    logic [UW-1:0]   user;
  } ar_chan_t;

  typedef struct packed {
    logic [DW-1:0]   data;
    logic [DW/8-1:0] strb;
    logic            last;
    logic [UW-1:0]   user;
  } w_chan_t;

  typedef struct packed {
    logic [IW-1:0]   id;
    logic [1:0]      resp;
    logic [UW-1:0]   user;
  } b_chan_t;

  typedef struct packed {
    logic [IW-1:0]   id;
    logic [DW-1:0]   data;
    logic [1:0]      resp;
    logic            last;
    logic [UW-1:0]   user;
  } r_chan_t;

  typedef struct packed {
    aw_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ar_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } req_t;

  typedef struct packed {
    logic     aw_ready;
    logic     ar_ready;
    logic     w_ready;
    logic     b_valid;
    b_chan_t  b;
    logic     r_valid;
    r_chan_t  r;
  } resp_t;
endpackage

// File: rtl/axi_traffic_gen.sv
// axi_traffic_gen: single-master AXI4 INCR burst generator for a zero memory.
// Issues num_bursts read or write bursts, one at a time, checks read data
// against zero, counts non-OKAY responses and counts busy cycles.
// Ports:
//   clk_i, rst_i (sync, active high)
//   start_i, write_i, base_addr_i, len_i, num_bursts_i : run configuration
//   busy_o, done_o, err_cnt_o, cycle_cnt_o            : run status
//   axi_req_o / axi_resp_i                            : AXI master port
module axi_traffic_gen #(
  parameter type         axi_req_t  = axi_traffic_gen_pkg::req_t,
  parameter type         axi_resp_t = axi_traffic_gen_pkg::resp_t,
  parameter int unsigned AddrWidth  = 32,
  parameter int unsigned DataWidth  = 64,
  parameter int unsigned IdWidth    = 1,
  parameter int unsigned CntWidth   = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 write_i,
  input  logic [AddrWidth-1:0] base_addr_i,
  input  logic [7:0]           len_i,
  input  logic [CntWidth-1:0]  num_bursts_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [CntWidth-1:0]  err_cnt_o,
  output logic [CntWidth-1:0]  cycle_cnt_o,
  output axi_req_t             axi_req_o,
  input  axi_resp_t            axi_resp_i
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ADDR  = 3'd1;
  localparam logic [2:0] S_WDATA = 3'd2;
  localparam logic [2:0] S_BRESP = 3'd3;
  localparam logic [2:0] S_RDATA = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam logic [2:0]         AxSize = 3'($clog2(DataWidth / 8));
  localparam logic [IdWidth-1:0] AxId   = '0;

  logic [2:0]           r_state, w_state_nxt;
  logic                 r_write;
  logic [AddrWidth-1:0] r_addr;
  logic [7:0]           r_len;
  logic [7:0]           r_beat;
  logic [CntWidth-1:0]  r_num, r_bcnt, r_err, r_cyc;

  logic                 w_busy, w_a_hs, w_last_beat, w_burst_end, w_r_fault;
  logic [CntWidth-1:0]  w_bcnt_nxt;
  logic [AddrWidth-1:0] w_incr;
  logic                 w_unused;

  function automatic logic [CntWidth-1:0] sat_inc(input logic [CntWidth-1:0] v);
    return (&v) ? v : v + CntWidth'(1);
  endfunction

  // Response fields not consumed here (ids, user bits) are intentionally ignored.
  assign w_unused = ^axi_resp_i;

  assign w_busy      = (r_state == S_ADDR) || (r_state == S_WDATA) ||
                       (r_state == S_BRESP) || (r_state == S_RDATA);
  assign busy_o      = w_busy;
  assign done_o      = (r_state == S_DONE);
  assign err_cnt_o   = r_err;
  assign cycle_cnt_o = r_cyc;

  assign w_a_hs      = r_write ? axi_resp_i.aw_ready : axi_resp_i.ar_ready;
  assign w_last_beat = (r_beat == r_len);
  // Bytes per burst: (len+1) beats of 2^AxSize bytes; wraps at 2^AddrWidth.
  assign w_incr      = AddrWidth'(9'(r_len) + 9'd1) << AxSize;
  assign w_bcnt_nxt  = sat_inc(r_bcnt);

  // A read beat is faulty on nonzero data, non-OKAY resp, or r_last that
  // disagrees with the beat index; several faults on one beat count once.
  assign w_r_fault = (|axi_resp_i.r.data) || (axi_resp_i.r.resp != 2'b00) ||
                     (axi_resp_i.r.last != w_last_beat);

  // Read bursts end on the len-th beat regardless of r_last.
  assign w_burst_end = ((r_state == S_BRESP) && axi_resp_i.b_valid) ||
                       ((r_state == S_RDATA) && axi_resp_i.r_valid && w_last_beat);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start_i) w_state_nxt = (num_bursts_i == '0) ? S_DONE : S_ADDR;
      S_ADDR:  if (w_a_hs) w_state_nxt = r_write ? S_WDATA : S_RDATA;
      S_WDATA: if (axi_resp_i.w_ready && w_last_beat) w_state_nxt = S_BRESP;
      S_BRESP,
      S_RDATA: if (w_burst_end) w_state_nxt = (w_bcnt_nxt == r_num) ? S_DONE : S_ADDR;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_write <= 1'b0;
      r_addr  <= '0;
      r_len   <= '0;
      r_beat  <= '0;
      r_num   <= '0;
      r_bcnt  <= '0;
      r_err   <= '0;
      r_cyc   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_busy) r_cyc <= sat_inc(r_cyc);
      case (r_state)
        S_IDLE: if (start_i) begin
          r_write <= write_i;
          r_addr  <= base_addr_i;
          r_len   <= len_i;
          r_num   <= num_bursts_i;
          r_bcnt  <= '0;
          r_beat  <= '0;
          r_err   <= '0;
          r_cyc   <= '0;
        end
        S_ADDR: if (w_a_hs) r_beat <= '0;
        S_WDATA: if (axi_resp_i.w_ready) r_beat <= r_beat + 8'd1;
        S_BRESP: if (axi_resp_i.b_valid && (axi_resp_i.b.resp != 2'b00)) r_err <= sat_inc(r_err);
        S_RDATA: if (axi_resp_i.r_valid) begin
          r_beat <= r_beat + 8'd1;
          if (w_r_fault) r_err <= sat_inc(r_err);
        end
        default: ;
      endcase
      if (w_burst_end) begin
        r_addr <= r_addr + w_incr;
        r_bcnt <= w_bcnt_nxt;
      end
    end
  end

  always_comb begin
    axi_req_o          = '0;
    axi_req_o.aw.id    = AxId;
    axi_req_o.aw.addr  = r_addr;
    axi_req_o.aw.len   = r_len;
    axi_req_o.aw.size  = AxSize;
    axi_req_o.aw.burst = 2'b01;
    axi_req_o.aw_valid = (r_state == S_ADDR) && r_write;
    axi_req_o.ar.id    = AxId;
    axi_req_o.ar.addr  = r_addr;
    axi_req_o.ar.len   = r_len;
    axi_req_o.ar.size  = AxSize;
    axi_req_o.ar.burst = 2'b01;
    axi_req_o.ar_valid = (r_state == S_ADDR) && !r_write;
    axi_req_o.w.data   = DataWidth'(r_beat);
    axi_req_o.w.strb   = '1;
    axi_req_o.w.last   = w_last_beat;
    axi_req_o.w_valid  = (r_state == S_WDATA);
    axi_req_o.b_ready  = (r_state == S_BRESP);
    axi_req_o.r_ready  = (r_state == S_RDATA);
  end

endmodule

// File: tb/tb_axi_traffic_gen.sv
// tb_axi_traffic_gen: randomized bench for axi_traffic_gen with a zero-memory
// responder (optional throttling and fault injection) and an arithmetic model
// of expected addresses, beat counts, error counts and cycle counts.
module tb_axi_traffic_gen;
  import axi_traffic_gen_pkg::*;

  logic        clk = 1'b0, rst = 1'b1, start = 1'b0, wr = 1'b0;
  logic [31:0] base = '0, num = '0;
  logic [7:0]  len = '0;
  logic        busy, done;
  logic [31:0] errc, cycc;
  req_t        req;
  resp_t       resp;

  always #5 clk = ~clk;

  axi_traffic_gen #(
    .axi_req_t(req_t), .axi_resp_t(resp_t),
    .AddrWidth(32), .DataWidth(64), .IdWidth(1), .CntWidth(32)
  ) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .write_i(wr),
    .base_addr_i(base), .len_i(len), .num_bursts_i(num),
    .busy_o(busy), .done_o(done), .err_cnt_o(errc), .cycle_cnt_o(cycc),
    .axi_req_o(req), .axi_resp_i(resp)
  );

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h @%0t", tag, act, exp, $time);
  endtask

  // responder / monitor state
  logic [31:0] ar_q[$], aw_q[$];
  int          r_beats, w_beats, b_cnt, done_cnt, stab_err, fld_err, w_err;
  bit          thr = 1'b0;
  int          f_data = 99, f_resp = 99, f_last = 99;
  logic [1:0]  f_bresp = 2'b00;
  logic [7:0]  cur_len = '0;

  int          rd_left, rd_idx, wr_idx;
  logic [7:0]  rd_len, wr_len;
  bit          b_pend;
  bit          p_awp, p_arp, p_wp;
  aw_chan_t    p_aw;
  ar_chan_t    p_ar;
  w_chan_t     p_w;

  function automatic aw_chan_t exp_aw(input logic [31:0] a, input logic [7:0] l);
    aw_chan_t x = '0;
    x.addr = a; x.len = l; x.size = 3'd3; x.burst = 2'b01;
    return x;
  endfunction

  function automatic ar_chan_t exp_ar(input logic [31:0] a, input logic [7:0] l);
    ar_chan_t x = '0;
    x.addr = a; x.len = l; x.size = 3'd3; x.burst = 2'b01;
    return x;
  endfunction

  function automatic bit coin();
    return !thr || ($urandom_range(0, 1) == 1);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      resp   <= '0;
      rd_left = 0; rd_idx = 0; wr_idx = 0; b_pend = 0;
      p_awp = 0; p_arp = 0; p_wp = 0;
    end else begin
      if (done) done_cnt++;
      // a pending valid must stay high with unchanged payload
      if (p_awp && (!req.aw_valid || req.aw != p_aw)) stab_err++;
      if (p_arp && (!req.ar_valid || req.ar != p_ar)) stab_err++;
      if (p_wp  && (!req.w_valid  || req.w  != p_w))  stab_err++;
      p_awp = req.aw_valid && !resp.aw_ready; p_aw = req.aw;
      p_arp = req.ar_valid && !resp.ar_ready; p_ar = req.ar;
      p_wp  = req.w_valid  && !resp.w_ready;  p_w  = req.w;

      if (req.ar_valid && resp.ar_ready) begin
        ar_q.push_back(req.ar.addr);
        if (req.ar != exp_ar(req.ar.addr, cur_len)) fld_err++;
        rd_left = int'(req.ar.len) + 1; rd_idx = 0; rd_len = req.ar.len;
      end
      if (resp.r_valid && req.r_ready) begin
        r_beats++; rd_idx++; rd_left--;
      end
      if (req.aw_valid && resp.aw_ready) begin
        aw_q.push_back(req.aw.addr);
        if (req.aw != exp_aw(req.aw.addr, cur_len)) fld_err++;
        wr_idx = 0; wr_len = req.aw.len;
      end
      if (req.w_valid && resp.w_ready) begin
        w_beats++;
        if (req.w.data != 64'(wr_idx) || req.w.strb != 8'hFF ||
            req.w.last != (wr_idx == int'(wr_len))) w_err++;
        if (wr_idx == int'(wr_len)) b_pend = 1;
        wr_idx++;
      end
      if (resp.b_valid && req.b_ready) b_cnt++;

      resp.aw_ready <= coin();
      resp.ar_ready <= coin();
      resp.w_ready  <= coin();

      if (resp.r_valid && !req.r_ready) begin
      end else if (rd_left > 0 && coin()) begin
        resp.r_valid  <= 1'b1;
        resp.r.data   <= (rd_idx == f_data) ? 64'h5 : 64'h0;
        resp.r.resp   <= (rd_idx == f_resp) ? 2'b10 : 2'b00;
        resp.r.last   <= (rd_idx == int'(rd_len)) ^ (rd_idx == f_last);
      end else resp.r_valid <= 1'b0;

      if (resp.b_valid && !req.b_ready) begin
      end else if (b_pend && coin()) begin
        resp.b_valid <= 1'b1;
        resp.b.resp  <= f_bresp;
        b_pend = 0;
      end else resp.b_valid <= 1'b0;
    end
  end

  task automatic run(input bit w, input logic [31:0] b, input logic [7:0] l,
                     input int n, input int exp_cyc, input bit poke);
    int          cyc, bad, e;
    logic [31:0] cyc_at_done;
    logic [31:0] q[$];
    @(negedge clk);
    ar_q.delete(); aw_q.delete();
    r_beats = 0; w_beats = 0; b_cnt = 0; done_cnt = 0;
    stab_err = 0; fld_err = 0; w_err = 0;
    cur_len = l;
    wr = w; base = b; len = l; num = n; start = 1'b1;
    @(posedge clk); #1;
    chk("busy_t1", busy, n != 0);
    chk("avalid_t1", w ? req.aw_valid : req.ar_valid, n != 0);
    if (n == 0) chk("done_t1", done, 1);
    @(negedge clk); start = 1'b0;
    cyc = 0;
    while (!done && cyc < 5000) begin
      @(posedge clk); #1; cyc++;
      if (poke && cyc == 3) begin start = 1'b1; wr = !w; num = n + 3; base = '0; end
      else start = 1'b0;
    end
    chk("timeout", cyc < 5000, 1);
    chk("busy_at_done", busy, 0);
    cyc_at_done = cycc;
    if (exp_cyc >= 0) chk("cycles", cycc, exp_cyc);
    @(posedge clk); #1;
    chk("done_one_cycle", done, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("cycles_hold", cycc, cyc_at_done);
    if (w) e = (f_bresp != 2'b00) ? n : 0;
    else begin
      bad = 0;
      for (int k = 0; k <= int'(l); k++)
        if (k == f_data || k == f_resp || k == f_last) bad++;
      e = n * bad;
    end
    chk("err_cnt", errc, e);
    chk("done_cnt", done_cnt, 1);
    chk("beats", w ? w_beats : r_beats, n * (int'(l) + 1));
    chk("b_cnt", b_cnt, w ? n : 0);
    chk("other_chan", w ? (ar_q.size() + r_beats) : (aw_q.size() + w_beats), 0);
    q = w ? aw_q : ar_q;
    chk("n_addr", q.size(), n);
    for (int k = 0; k < q.size(); k++)
      chk("addr", q[k], 32'(b + 32'(k * (int'(l) + 1) * 8)));
    chk("stable", stab_err, 0);
    chk("fields", fld_err, 0);
    chk("wbeats", w_err, 0);
  endtask

  initial begin
    int cyc;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", errc, 0);
    chk("rst_cyc", cycc, 0);
    chk("rst_valids", {req.aw_valid, req.ar_valid, req.w_valid, req.b_ready, req.r_ready}, 0);
    @(negedge clk); rst = 1'b0;

    thr = 1'b0;
    run(0, 32'h1000, 8'd3, 4, 20, 0);
    run(1, 32'h2000, 8'd7, 2, 20, 0);
    f_data = 0; f_resp = 1;
    run(0, 32'h3000, 8'd1, 1, 3, 0);
    f_data = 99; f_resp = 99;
    f_bresp = 2'b11;
    run(1, 32'h4000, 8'd0, 1, 3, 0);
    f_bresp = 2'b00;
    run(0, 32'h0, 8'd5, 0, 0, 0);
    run(0, 32'hFFFF_FFF8, 8'd0, 2, 4, 0);
    run(0, 32'h5000, 8'd3, 2, 10, 1);

    thr = 1'b1;
    for (int i = 0; i < 8; i++) begin
      f_data  = $urandom_range(0, 20);
      f_resp  = $urandom_range(0, 20);
      f_last  = $urandom_range(0, 20);
      f_bresp = 2'($urandom_range(0, 3));
      run(1'($urandom_range(0, 1)), ($urandom & 32'hFFFF_F000) + 32'($urandom_range(0, 15) * 128),
          8'($urandom_range(0, 15)), $urandom_range(1, 4), -1, 0);
    end
    f_data = 99; f_resp = 99; f_last = 99; f_bresp = 2'b00;
    thr = 1'b0;

    // reset in the middle of a write data phase
    @(negedge clk);
    cur_len = 8'd7; wr = 1'b1; base = 32'h7000; len = 8'd7; num = 2; start = 1'b1;
    @(negedge clk); start = 1'b0;
    cyc = 0;
    while (!req.w_valid && cyc < 100) begin @(negedge clk); cyc++; end
    chk("wdata_reached", req.w_valid, 1);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_cyc", cycc, 0);
    chk("mid_rst_err", errc, 0);
    chk("mid_rst_valids", {req.aw_valid, req.ar_valid, req.w_valid, req.b_ready, req.r_ready}, 0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    run(0, 32'h6000, 8'd2, 3, 12, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
